// File: rtl/frv_pipeline_decode_pc_pkg.sv
// Shared constants for the decode-side PC tracker: fault codes and
// instruction length-decode patterns.
package frv_pipeline_decode_pc_pkg;

   localparam int XL = 31;

   localparam logic [1:0] FAULT_NONE  = 2'b00;
   localparam logic [1:0] FAULT_FETCH = 2'b01;
   localparam logic [1:0] FAULT_LEN   = 2'b10;

   localparam logic [1:0] OPC_LEN32 = 2'b11;
   localparam logic [4:0] OPC_LEN48 = 5'b11111;

   // A fetch bus error outranks an unsupported-length encoding.
   function automatic logic [1:0] classify_fault(input logic [4:0] opc, input logic bus_err);
      if (bus_err)
         return FAULT_FETCH;
      else if (opc == OPC_LEN48)
         return FAULT_LEN;
      else
         return FAULT_NONE;
   endfunction

endpackage

// File: rtl/frv_pipeline_decode_pc_skid_fifo2.sv
// Two-entry FIFO with flush and a registered full flag, used as the skid
// buffer between fetch and decode.
module frv_pipeline_decode_pc_skid_fifo2 #(
   parameter int WIDTH = 8
)(
   input  logic             g_clk,
   input  logic             g_reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [1:0]       count,
   output logic             full
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       next_count;

   always_comb begin
      next_count = count;
      if (flush)
         next_count = 2'd0;
      else if (push && !pop)
         next_count = count + 2'd1;
      else if (pop && !push)
         next_count = count - 2'd1;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         count  <= 2'd0;
         full   <= 1'b0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         count <= next_count;
         full  <= (next_count == 2'd2);
         if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
         end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Storage needs no reset: an empty FIFO masks it at the output.
   always_ff @(posedge g_clk) begin
      if (push && !flush)
         mem[wr_ptr] <= wdata;
   end

   assign rdata = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/frv_pipeline_decode_pc.sv
// Decode front end: tracks the PC of each fetched instruction, classifies
// its length/fault and buffers it towards the s2 stage.
module frv_pipeline_decode_pc
   import frv_pipeline_decode_pc_pkg::*;
#(
   parameter int              XLEN               = 32,
   parameter logic [XLEN-1:0] FRV_PC_RESET_VALUE = 32'h8000_0000
)(
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            cf_req,
   input  logic            cf_ack,
   input  logic [XLEN-1:0] cf_target,
   input  logic            s1_valid,
   input  logic [XLEN-1:0] s1_data,
   input  logic            s1_error,
   output logic            s1_busy,
   output logic            s2_valid,
   input  logic            s2_busy,
   output logic [XLEN-1:0] s2_instr,
   output logic [XLEN-1:0] s2_pc,
   output logic [XLEN-1:0] s2_npc,
   output logic            s2_size,
   output logic [1:0]      s2_fault
);

   localparam int EW = 3*XLEN + 3;

   logic            cf_event;
   logic            accept;
   logic            push;
   logic            pop;
   logic            size;
   logic [1:0]      fault;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] npc;
   logic [EW-1:0]   wdata;
   logic [EW-1:0]   rdata;
   logic [1:0]      count;

   assign cf_event = cf_req && cf_ack;
   assign accept   = s1_valid && !s1_busy;
   assign pop      = s2_valid && !s2_busy;
   // A control-flow change drops the instruction arriving alongside it.
   assign push     = accept && !cf_event;

   assign size  = (s1_data[1:0] == OPC_LEN32);
   assign fault = classify_fault(s1_data[4:0], s1_error);
   assign instr = size ? s1_data : {{(XLEN-16){1'b0}}, s1_data[15:0]};
   assign npc   = pc_q + (size ? XLEN'(4) : XLEN'(2));

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset)
         pc_q <= FRV_PC_RESET_VALUE;
      else if (cf_event)
         pc_q <= {cf_target[XLEN-1:1], 1'b0};
      else if (accept)
         pc_q <= npc;
   end

   assign wdata = {instr, pc_q, npc, size, fault};

   frv_pipeline_decode_pc_skid_fifo2 #(
      .WIDTH (EW)
   ) u_fifo (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .push    (push),
      .pop     (pop),
      .flush   (cf_event),
      .wdata   (wdata),
      .rdata   (rdata),
      .count   (count),
      .full    (s1_busy)
   );

   assign s2_valid = (count != 2'd0);
   assign {s2_instr, s2_pc, s2_npc, s2_size, s2_fault} = rdata;

endmodule

// File: tb/tb_frv_pipeline_decode_pc.sv
// Scoreboard bench: the driver pushes expected entries from a queue model,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_frv_pipeline_decode_pc;

   localparam logic [31:0] PC_RST = 32'h8000_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        size;
      logic [1:0]  fault;
   } ent_t;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        cf_req = 1'b0;
   logic        cf_ack = 1'b0;
   logic [31:0] cf_target = '0;
   logic        s1_valid = 1'b0;
   logic [31:0] s1_data = '0;
   logic        s1_error = 1'b0;
   logic        s1_busy;
   logic        s2_valid;
   logic        s2_busy = 1'b0;
   logic [31:0] s2_instr;
   logic [31:0] s2_pc;
   logic [31:0] s2_npc;
   logic        s2_size;
   logic [1:0]  s2_fault;

   ent_t        exp_q[$];
   logic [31:0] model_pc = PC_RST;
   logic        model_busy = 1'b0;
   logic        in_reset = 1'b1;
   int          total = 0;
   int          bad = 0;

   frv_pipeline_decode_pc dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .cf_req    (cf_req),
      .cf_ack    (cf_ack),
      .cf_target (cf_target),
      .s1_valid  (s1_valid),
      .s1_data   (s1_data),
      .s1_error  (s1_error),
      .s1_busy   (s1_busy),
      .s2_valid  (s2_valid),
      .s2_busy   (s2_busy),
      .s2_instr  (s2_instr),
      .s2_pc     (s2_pc),
      .s2_npc    (s2_npc),
      .s2_size   (s2_size),
      .s2_fault  (s2_fault)
   );

   always #5 g_clk = ~g_clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: entry contents come straight from the length/fault rules.
   function automatic ent_t model_entry(logic [31:0] data, logic err, logic [31:0] pc);
      ent_t e;
      e.size  = ((data & 32'h3) == 32'h3);
      e.instr = e.size ? data : (data & 32'h0000_FFFF);
      e.pc    = pc;
      e.npc   = pc + (e.size ? 32'd4 : 32'd2);
      if (err)
         e.fault = 2'd1;
      else if ((data & 32'h1F) == 32'h1F)
         e.fault = 2'd2;
      else
         e.fault = 2'd0;
      return e;
   endfunction

   always @(negedge g_clk) begin
      if (!in_reset) begin
         chk("s1_busy", {31'd0, s1_busy}, {31'd0, model_busy});
         chk("s2_valid", {31'd0, s2_valid}, {31'd0, exp_q.size() != 0});
         if (s2_valid && exp_q.size() != 0) begin
            chk("s2_instr", s2_instr, exp_q[0].instr);
            chk("s2_pc", s2_pc, exp_q[0].pc);
            chk("s2_npc", s2_npc, exp_q[0].npc);
            chk("s2_size_fault", {29'd0, s2_size, s2_fault}, {29'd0, exp_q[0].size, exp_q[0].fault});
            if (!s2_busy) void'(exp_q.pop_front());
         end else if (!s2_valid) begin
            chk("empty_pc", s2_pc | s2_npc | s2_instr, 32'd0);
         end
      end
   end

   // One cycle: apply inputs, let the edge happen, then update the model.
   task automatic step(input logic v, input logic [31:0] data, input logic err,
                       input logic b2, input logic cfr, input logic cfa,
                       input logic [31:0] tgt);
      logic acc;
      logic cfe;
      s1_valid  = v;
      s1_data   = data;
      s1_error  = err;
      s2_busy   = b2;
      cf_req    = cfr;
      cf_ack    = cfa;
      cf_target = tgt;
      acc = v && !model_busy;
      cfe = cfr && cfa;
      @(posedge g_clk);
      #1;
      if (cfe) begin
         exp_q.delete();
         model_pc = tgt & 32'hFFFF_FFFE;
      end else if (acc) begin
         exp_q.push_back(model_entry(data, err, model_pc));
         model_pc = model_pc + ((((data & 32'h3) == 32'h3)) ? 32'd4 : 32'd2);
      end
      model_busy = (exp_q.size() == 2);
   endtask

   task automatic idle(input logic b2);
      step(1'b0, 32'd0, 1'b0, b2, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge g_clk);
      #1;
      chk("rst_s2_valid", {31'd0, s2_valid}, 32'd0);
      chk("rst_s1_busy", {31'd0, s1_busy}, 32'd0);
      chk("rst_outputs", s2_pc | s2_npc | s2_instr | {29'd0, s2_size, s2_fault}, 32'd0);
      g_reset  = 1'b0;
      in_reset = 1'b0;

      step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'hFFFF_4501, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      idle(1'b0);
      idle(1'b0);

      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h0000_0100 + 32'(i * 4) + 32'h3, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      repeat (4) idle(1'b0);

      step(1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0103);
      step(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'h0000_001F, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'h0000_001F, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      idle(1'b0);

      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
      step(1'b1, 32'h0000_4502, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 32'h0000_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (2) idle(1'b0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] d;
         logic [31:0] t;
         logic        cr;
         d = $urandom();
         if ($urandom_range(0, 5) == 0) d = d | 32'h1F;
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom();
         cr = ($urandom_range(0, 19) == 0);
         step($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0, cr, cr && ($urandom_range(0, 1) == 1), t);
      end
      repeat (3) idle(1'b0);

      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h0000_0213 + 32'(i << 8), 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      #2;
      in_reset = 1'b1;
      g_reset  = 1'b1;
      #1;
      chk("async_rst_s2_valid", {31'd0, s2_valid}, 32'd0);
      chk("async_rst_s1_busy", {31'd0, s1_busy}, 32'd0);
      chk("async_rst_outputs", s2_pc | s2_npc | s2_instr, 32'd0);
      s1_valid = 1'b0;
      @(posedge g_clk);
      #1;
      g_reset = 1'b0;
      exp_q.delete();
      model_pc   = PC_RST;
      model_busy = 1'b0;
      in_reset   = 1'b0;
      step(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (2) idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
